branch_resolve_unit: RTL and testbench

//  Parametrised, pipelined branch resolution unit for the EX stage of the RV32I pipeline.

---
 rtl/branch_resolve_unit.sv | 176 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: evaluates the RV32I conditional branch ops, resolves the next PC,
// flags mispredicts against the fetch prediction and keeps saturating statistics counters.
module branch_resolve_unit #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 1,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_cmpop,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_mispred
);

  typedef struct packed {
    logic             eq;
    logic             lts;
    logic             ltu;
    logic [2:0]       cmpop;
    logic [XLEN-1:0]  pc_imm;
    logic [XLEN-1:0]  pc4;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             taken;
    logic             mispredict;
    logic             illegal;
    logic [XLEN-1:0]  target;
    logic [TAG_W-1:0] tag;
  } s2_t;

  // Handshake: a transfer happens on valid & ready at a rising edge. The whole pipe
  // stalls as one unit whenever the output holds a result the consumer has not taken.
  logic advance;
  logic accept;
  logic deliver;
  s1_t  s1_in;
  s1_t  s1;
  logic s1_valid;
  s2_t  s2_res;
  s2_t  s2_d, s2_q;
  logic s2_valid_d, s2_valid_q;
  logic [CNT_W-1:0] cnt_branches_d, cnt_branches_q;
  logic [CNT_W-1:0] cnt_mispred_d, cnt_mispred_q;

  assign advance  = !s2_valid_q || out_ready;
  assign in_ready = advance && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_in             = '0;
    s1_in.eq          = (in_a == in_b);
    s1_in.lts         = ($signed(in_a) < $signed(in_b));
    s1_in.ltu         = (in_a < in_b);
    s1_in.cmpop       = in_cmpop;
    s1_in.pc_imm      = in_pc + in_imm;
    s1_in.pc4         = in_pc + XLEN'(4);
    s1_in.pred_taken  = in_pred_taken;
    s1_in.pred_target = in_pred_target;
    s1_in.tag         = in_tag;
  end

  generate
    if (LATENCY == 2) begin : g_two_stage
      s1_t  s1_d, s1_q;
      logic s1_valid_d, s1_valid_q;

      always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (flush) begin
          s1_valid_d = 1'b0;
        end else if (advance) begin
          s1_valid_d = accept;
          s1_d       = s1_in;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) s1_valid_q <= 1'b0;
        else        s1_valid_q <= s1_valid_d;
        s1_q <= s1_d;
      end

      assign s1       = s1_q;
      assign s1_valid = s1_valid_q;
    end else if (LATENCY == 1) begin : g_one_stage
      assign s1       = s1_in;
      assign s1_valid = accept;
    end else begin : g_bad_latency
      $error("branch_resolve_unit: LATENCY must be 1 or 2");
    end
  endgenerate

  always_comb begin
    s2_res     = '0;
    s2_res.tag = s1.tag;
    case (s1.cmpop)
      3'b000:  s2_res.taken = s1.eq;
      3'b001:  s2_res.taken = !s1.eq;
      3'b100:  s2_res.taken = s1.lts;
      3'b101:  s2_res.taken = !s1.lts;
      3'b110:  s2_res.taken = s1.ltu;
      3'b111:  s2_res.taken = !s1.ltu;
      default: s2_res.illegal = 1'b1;
    endcase
    s2_res.target     = s2_res.taken ? s1.pc_imm : s1.pc4;
    // A not-taken prediction carries no target, so only taken/taken pairs compare targets.
    s2_res.mispredict = (s2_res.taken != s1.pred_taken) ||
                        (s2_res.taken && s1.pred_taken && (s2_res.target != s1.pred_target));
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (advance) begin
      s2_valid_d = s1_valid;
      s2_d       = s2_res;
    end
  end

  assign out_valid = s2_valid_q && !flush;
  assign deliver   = out_valid && out_ready;

  always_comb begin
    cnt_branches_d = cnt_branches_q;
    cnt_mispred_d  = cnt_mispred_q;
    if (deliver && (cnt_branches_q != '1)) cnt_branches_d = cnt_branches_q + CNT_W'(1);
    if (deliver && s2_q.mispredict && (cnt_mispred_q != '1)) cnt_mispred_d = cnt_mispred_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q     <= 1'b0;
      cnt_branches_q <= '0;
      cnt_mispred_q  <= '0;
    end else begin
      s2_valid_q     <= s2_valid_d;
      cnt_branches_q <= cnt_branches_d;
      cnt_mispred_q  <= cnt_mispred_d;
    end
    s2_q <= s2_d;
  end

  assign out_taken      = out_valid && s2_q.taken;
  assign out_mispredict = out_valid && s2_q.mispredict;
  assign out_illegal    = out_valid && s2_q.illegal;
  assign out_target     = out_valid ? s2_q.target : '0;
  assign out_tag        = out_valid ? s2_q.tag : '0;
  assign cnt_branches   = cnt_branches_q;
  assign cnt_mispred    = cnt_mispred_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: a LATENCY=1/CNT_W=16 and a LATENCY=2/CNT_W=4 instance share
// one stimulus stream; each is compared every cycle against its own reference model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, out_ready, in_pred_taken;
  logic [2:0]  in_cmpop;
  logic [31:0] in_a, in_b, in_pc, in_imm, in_pred_target;
  logic [3:0]  in_tag;

  logic [1:0]  in_ready_w, out_valid_w, out_taken_w, out_mispredict_w, out_illegal_w;
  logic [31:0] out_target_w [2];
  logic [3:0]  out_tag_w [2];
  logic [15:0] cnt_br0, cnt_mp0;
  logic [3:0]  cnt_br1, cnt_mp1;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .LATENCY(1), .TAG_W(4), .CNT_W(16)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_cmpop(in_cmpop), .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_taken(out_taken_w[0]), .out_target(out_target_w[0]),
    .out_mispredict(out_mispredict_w[0]), .out_illegal(out_illegal_w[0]),
    .out_tag(out_tag_w[0]), .cnt_branches(cnt_br0), .cnt_mispred(cnt_mp0)
  );

  branch_resolve_unit #(.XLEN(32), .LATENCY(2), .TAG_W(4), .CNT_W(4)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_cmpop(in_cmpop), .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_taken(out_taken_w[1]), .out_target(out_target_w[1]),
    .out_mispredict(out_mispredict_w[1]), .out_illegal(out_illegal_w[1]),
    .out_tag(out_tag_w[1]), .cnt_branches(cnt_br1), .cnt_mispred(cnt_mp1)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: per instance, occupancy bits per pipeline slot plus an ordered queue of
  // expected results {taken, mispredict, illegal, target[31:0], tag[3:0]}.
  bit          sv [2][2];
  int          m_br [2];
  int          m_mp [2];
  bit          m_acc [2];
  logic [38:0] exp_q0[$];
  logic [38:0] exp_q1[$];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int cap_of(input int d);
    return (d == 0) ? 65535 : 15;
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [38:0] q_front(input int d);
    if (q_size(d) == 0) return '0;
    return (d == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic q_push(input int d, input logic [38:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic q_pop(input int d);
    if (d == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endtask

  task automatic q_clear(input int d);
    if (d == 0) exp_q0.delete();
    else        exp_q1.delete();
  endtask

  function automatic logic [38:0] resolve(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] pc, input logic [31:0] imm, input logic pt,
                                          input logic [31:0] ptgt, input logic [3:0] tag);
    logic taken, ill, mp;
    logic [31:0] tgt;
    int sa, sb;
    sa = a; sb = b;
    ill = 1'b0;
    case (op)
      3'd0: taken = (a == b);
      3'd1: taken = (a != b);
      3'd4: taken = (sa < sb);
      3'd5: taken = (sa >= sb);
      3'd6: taken = (a < b);
      3'd7: taken = (a >= b);
      default: begin taken = 1'b0; ill = 1'b1; end
    endcase
    tgt = taken ? (pc + imm) : (pc + 32'd4);
    mp  = (taken != pt) || (taken && pt && (tgt != ptgt));
    return {taken, mp, ill, tgt, tag};
  endfunction

  task automatic check_dut(input int d);
    int last;
    logic exp_v, exp_rdy;
    logic [38:0] e;
    last    = lat_of(d) - 1;
    exp_v   = sv[d][last] && !flush;
    exp_rdy = (!sv[d][last] || out_ready) && !flush;
    e = '0;
    if (exp_v) begin
      check($sformatf("dut%0d.q_nonempty", d), 64'(q_size(d) > 0), 64'd1);
      e = q_front(d);
    end
    check($sformatf("dut%0d.in_ready", d), in_ready_w[d], exp_rdy);
    check($sformatf("dut%0d.out_valid", d), out_valid_w[d], exp_v);
    check($sformatf("dut%0d.out_taken", d), out_taken_w[d], e[38]);
    check($sformatf("dut%0d.out_mispredict", d), out_mispredict_w[d], e[37]);
    check($sformatf("dut%0d.out_illegal", d), out_illegal_w[d], e[36]);
    check($sformatf("dut%0d.out_target", d), out_target_w[d], e[35:4]);
    check($sformatf("dut%0d.out_tag", d), out_tag_w[d], e[3:0]);
    check($sformatf("dut%0d.cnt_branches", d), (d == 0) ? 64'(cnt_br0) : 64'(cnt_br1), 64'(m_br[d]));
    check($sformatf("dut%0d.cnt_mispred", d), (d == 0) ? 64'(cnt_mp0) : 64'(cnt_mp1), 64'(m_mp[d]));
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int  last;
      bit  adv, acc;
      last = lat_of(d) - 1;
      adv  = !sv[d][last] || out_ready;
      acc  = in_valid && adv && !flush;
      m_acc[d] = acc && rst_n;
      if (!rst_n) begin
        sv[d][0] = 1'b0; sv[d][1] = 1'b0;
        m_br[d] = 0; m_mp[d] = 0;
        q_clear(d);
      end else if (flush) begin
        sv[d][0] = 1'b0; sv[d][1] = 1'b0;
        q_clear(d);
      end else begin
        if (sv[d][last] && out_ready) begin
          if (m_br[d] < cap_of(d)) m_br[d]++;
          if (q_front(d) [37] && m_mp[d] < cap_of(d)) m_mp[d]++;
          q_pop(d);
        end
        if (adv) begin
          if (last == 1) sv[d][1] = sv[d][0];
          sv[d][0] = acc;
          if (acc) q_push(d, resolve(in_cmpop, in_a, in_b, in_pc, in_imm, in_pred_taken, in_pred_target, in_tag));
        end
      end
    end
  endtask

  // Inputs are set just after a falling edge; outputs are sampled 1 time unit later.
  task automatic cycle();
    #1;
    if (chk_en) begin
      check_dut(0);
      check_dut(1);
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm, input logic pt,
                        input logic [31:0] ptgt, input logic [3:0] tag);
    in_valid = 1'b1; in_cmpop = op; in_a = a; in_b = b; in_pc = pc; in_imm = imm;
    in_pred_taken = pt; in_pred_target = ptgt; in_tag = tag;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_op(3'd0, 0, 0, 0, 0, 1'b0, 0, 4'd0);
    in_valid = 1'b0;
    @(negedge clk);
    cycle();
    chk_en = 1'b1;
    cycle();
    rst_n = 1'b1;
    idle(2);

    // beq equal operands, predicted not-taken
    set_op(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0, 4'd1);
    cycle();
    idle(3);

    // signed vs unsigned compare on the same operands, back to back
    set_op(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1, 32'h240, 4'd2);
    cycle();
    set_op(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1, 32'h340, 4'd3);
    cycle();
    idle(3);

    // consumer stalls for 3 cycles while tags 1..3 are offered
    begin
      int k;
      k = 1;
      for (int i = 0; i < 12; i++) begin
        out_ready = (i >= 3);
        if (k <= 3) set_op(3'($urandom_range(4, 7)), $urandom, $urandom, $urandom, $urandom,
                           1'($urandom_range(0, 1)), $urandom, 4'(k));
        else in_valid = 1'b0;
        cycle();
        if (k <= 3 && m_acc[1]) k++;
      end
    end
    idle(2);

    // flush with one op in each stage, then a fresh op right after
    set_op(3'b001, 32'd1, 32'd2, 32'h400, 32'h10, 1'b0, 32'h0, 4'd5);
    cycle();
    set_op(3'b000, 32'd1, 32'd2, 32'h500, 32'h10, 1'b1, 32'h510, 4'd6);
    cycle();
    flush = 1'b1;
    set_op(3'b000, 32'd7, 32'd7, 32'h600, 32'h10, 1'b0, 32'h0, 4'd7);
    cycle();
    flush = 1'b0;
    set_op(3'b101, 32'd9, 32'd3, 32'h700, 32'h8, 1'b1, 32'h708, 4'd8);
    cycle();
    idle(3);

    // PC wrap and illegal cmpop
    set_op(3'b001, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'd8, 1'b1, 32'h4, 4'd9);
    cycle();
    set_op(3'b011, 32'd1, 32'd1, 32'h800, 32'h10, 1'b1, 32'h810, 4'd10);
    cycle();
    set_op(3'b010, 32'd1, 32'd1, 32'h900, 32'h10, 1'b0, 32'h0, 4'd11);
    cycle();
    idle(3);

    // saturate the 4-bit counters of the LATENCY=2 instance
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_op(3'b000, 32'd3, 32'd3, $urandom, $urandom, 1'b0, 32'h0, 4'(i));
      cycle();
    end
    idle(3);
    check("sat.cnt_branches", 64'(cnt_br1), 64'd15);
    check("sat.cnt_mispred", 64'(cnt_mp1), 64'd15);
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    check("rst.cnt_branches", 64'(cnt_br1), 64'd0);
    check("rst.out_valid", 64'(out_valid_w[1]), 64'd0);
    idle(2);

    // randomized traffic with stalls, flushes and occasional reset
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc, imm;
      rst_n     = ($urandom_range(0, 127) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      pc  = $urandom;
      imm = $urandom;
      set_op(3'($urandom_range(0, 7)),
             ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom,
             ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom,
             pc, imm, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) != 0) ? (pc + imm) : $urandom, 4'($urandom_range(0, 15)));
      in_valid = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rst_n = 1'b1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
